// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with valid/ready handshake.
// Decodes the immediate format from opcode/funct3 and holds results in a two-entry
// buffer (output register O plus skid register S). This gives full throughput under
// backpressure while in_ready depends only on registered state and rst.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam bit Rv64 = (XLEN == 64);

  // Opcodes
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpReg32  = 7'b0111011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  // Format codes
  localparam logic [2:0] FmtI     = 3'b000;
  localparam logic [2:0] FmtU     = 3'b001;
  localparam logic [2:0] FmtJ     = 3'b010;
  localparam logic [2:0] FmtB     = 3'b011;
  localparam logic [2:0] FmtShamt = 3'b100;
  localparam logic [2:0] FmtNone  = 3'b101;
  localparam logic [2:0] FmtS     = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam entry_t EntryRst = '{imm: '0, fmt: FmtNone, ill: 1'b0, tag: '0};

  // Field extraction and sign-extended immediate candidates
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_is_shift;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt5;
  logic [XLEN-1:0] w_shamt6;

  assign w_opcode   = in_instr[6:0];
  assign w_funct3   = in_instr[14:12];
  assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

  assign w_imm_i  = XLEN'($signed(in_instr[31:20]));
  assign w_imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign w_imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                   in_instr[11:8], 1'b0}));
  assign w_imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                   in_instr[30:21], 1'b0}));
  assign w_imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign w_shamt5 = {{(XLEN-5){1'b0}}, in_instr[24:20]};
  assign w_shamt6 = {{(XLEN-6){1'b0}}, in_instr[25:20]};

  // Decoded result for the instruction currently on in_instr
  entry_t w_dec;

  // Format decode and immediate selection
  always_comb begin
    w_dec.imm = '0;
    w_dec.fmt = FmtNone;
    w_dec.ill = 1'b0;
    w_dec.tag = in_tag;
    case (w_opcode)
      OpLoad, OpJalr, OpFence, OpSystem: begin
        w_dec.fmt = FmtI;
        w_dec.imm = w_imm_i;
      end
      OpImm: begin
        if (w_is_shift) begin
          w_dec.fmt = FmtShamt;
          if (Rv64) begin
            w_dec.imm = w_shamt6;
          end else begin
            w_dec.imm = w_shamt5;
            w_dec.ill = in_instr[25];
          end
        end else begin
          w_dec.fmt = FmtI;
          w_dec.imm = w_imm_i;
        end
      end
      OpImm32: begin
        if (w_is_shift) begin
          w_dec.fmt = FmtShamt;
          w_dec.imm = w_shamt5;
          w_dec.ill = in_instr[25];
        end else begin
          w_dec.fmt = FmtI;
          w_dec.imm = w_imm_i;
        end
        // Word ops only exist on RV64
        if (!Rv64) w_dec.ill = 1'b1;
      end
      OpStore: begin
        w_dec.fmt = FmtS;
        w_dec.imm = w_imm_s;
      end
      OpBranch: begin
        w_dec.fmt = FmtB;
        w_dec.imm = w_imm_b;
      end
      OpLui, OpAuipc: begin
        w_dec.fmt = FmtU;
        w_dec.imm = w_imm_u;
      end
      OpJal: begin
        w_dec.fmt = FmtJ;
        w_dec.imm = w_imm_j;
      end
      OpReg: begin
        w_dec.fmt = FmtNone;
      end
      OpReg32: begin
        w_dec.fmt = FmtNone;
        if (!Rv64) w_dec.ill = 1'b1;
      end
      default: begin
        w_dec.fmt = FmtNone;
        w_dec.ill = 1'b1;
      end
    endcase
  end

  // Buffer state: O drives the outputs, S catches one entry while O is stalled
  entry_t r_o;
  entry_t r_s;
  logic   r_o_valid;
  logic   r_s_valid;

  entry_t w_o_nxt;
  entry_t w_s_nxt;
  logic   w_o_valid_nxt;
  logic   w_s_valid_nxt;
  logic   w_accept;
  logic   w_o_load;
  logic   w_s_load;

  assign in_ready = !rst && !r_s_valid;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_o_load = !r_o_valid || out_ready;
  // O valid and stalled implies O is not loading this cycle
  assign w_s_load = w_accept && r_o_valid && !out_ready;

  // Next-state for O and S: S drains into O first to keep FIFO order
  always_comb begin
    w_o_nxt       = r_o;
    w_s_nxt       = r_s;
    w_o_valid_nxt = r_o_valid;
    w_s_valid_nxt = r_s_valid;
    if (flush) begin
      w_o_valid_nxt = 1'b0;
      w_s_valid_nxt = 1'b0;
    end else begin
      if (w_o_load) begin
        if (r_s_valid) begin
          w_o_nxt       = r_s;
          w_o_valid_nxt = 1'b1;
          w_s_valid_nxt = 1'b0;
        end else if (w_accept) begin
          w_o_nxt       = w_dec;
          w_o_valid_nxt = 1'b1;
        end else begin
          w_o_valid_nxt = 1'b0;
        end
      end
      if (w_s_load) begin
        w_s_nxt       = w_dec;
        w_s_valid_nxt = 1'b1;
      end
    end
  end

  // Buffer registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o       <= EntryRst;
      r_s       <= EntryRst;
      r_o_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else begin
      r_o       <= w_o_nxt;
      r_s       <= w_s_nxt;
      r_o_valid <= w_o_valid_nxt;
      r_s_valid <= w_s_valid_nxt;
    end
  end

  assign out_valid   = r_o_valid;
  assign out_imm     = r_o.imm;
  assign out_fmt     = r_o.fmt;
  assign out_illegal = r_o.ill;
  assign out_tag     = r_o.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus
// stream; a reference model predicts each accepted instruction and monitors compare
// whatever each instance delivers.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_tag = '0;

  logic        rdy32, rdy64, ov32, ov64, ill32, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [31:0] tag32, tag64;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   del_cyc[$];

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
    .in_tag(in_tag), .flush(flush), .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
    .in_tag(in_tag), .flush(flush), .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Reference: immediate as a plain integer, then wrapped to the XLEN width
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] tag,
                                 input int xlen);
    exp_t e;
    longint v;
    logic [6:0] op;
    logic [2:0] f3;
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [19:0] u20;
    logic signed [20:0] j21;
    op = ins[6:0];
    f3 = ins[14:12];
    v = 0;
    e.tag = tag;
    e.ill = 1'b0;
    e.fmt = 3'b101;
    case (op)
      7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        e.fmt = 3'b000; i12 = ins[31:20]; v = i12;
      end
      7'b0010011, 7'b0011011: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.fmt = 3'b100;
          if (xlen == 64 && op == 7'b0010011) v = ins[25:20];
          else begin v = ins[24:20]; e.ill = ins[25]; end
        end else begin
          e.fmt = 3'b000; i12 = ins[31:20]; v = i12;
        end
      end
      7'b0100011: begin e.fmt = 3'b111; i12 = {ins[31:25], ins[11:7]}; v = i12; end
      7'b1100011: begin
        e.fmt = 3'b011; b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; v = b13;
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = 3'b001; u20 = ins[31:12]; v = longint'(u20) * 4096;
      end
      7'b1101111: begin
        e.fmt = 3'b010; j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; v = j21;
      end
      7'b0110011, 7'b0111011: e.fmt = 3'b101;
      default: e.ill = 1'b1;
    endcase
    if (xlen == 32 && (op == 7'b0011011 || op == 7'b0111011)) e.ill = 1'b1;
    e.imm = (xlen == 32) ? (v & 64'hFFFF_FFFF) : v;
    return e;
  endfunction

  // Expectation producer: decide acceptance just before the coming edge
  initial forever begin
    @(negedge clk); #1;
    if (rst || flush) begin
      q32.delete();
      q64.delete();
    end else if (in_valid && rdy32) begin
      q32.push_back(model(in_instr, in_tag, 32));
      q64.push_back(model(in_instr, in_tag, 64));
    end
  end

  // Monitor for the XLEN=32 instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ov32 && out_ready) begin
        del_cyc.push_back(cyc);
        if (q32.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL mon32_unexpected: got tag %0h, want no output", tag32);
        end else begin
          e = q32.pop_front();
          check("mon32_imm", {32'b0, imm32}, e.imm);
          check("mon32_fmt", fmt32, e.fmt);
          check("mon32_ill", ill32, e.ill);
          check("mon32_tag", tag32, e.tag);
        end
      end
    end
  end

  // Monitor for the XLEN=64 instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ov64 && out_ready) begin
        if (q64.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL mon64_unexpected: got tag %0h, want no output", tag64);
        end else begin
          e = q64.pop_front();
          check("mon64_imm", imm64, e.imm);
          check("mon64_fmt", fmt64, e.fmt);
          check("mon64_ill", ill64, e.ill);
          check("mon64_tag", tag64, e.tag);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] tag);
    in_valid = 1'b1;
    in_instr = ins;
    in_tag = tag;
  endtask

  // Offer until accepted; returns just before the accepting edge
  task automatic send(input logic [31:0] ins, input logic [31:0] tag, output bit ok);
    tick();
    offer(ins, tag);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); #1;
      if (rdy32) begin
        ok = 1'b1;
        return;
      end
      tick();
      offer(ins, tag);
    end
    n_chk++; n_err++;
    $display("FAIL send_timeout: got no accept for tag %0h, want accept within 50", tag);
    ok = 1'b0;
  endtask

  task automatic drain();
    rand_rdy = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      out_ready = 1'b1;
      @(negedge clk); #1;
      if (q32.size() == 0 && q64.size() == 0 && !ov32 && !ov64) return;
    end
    n_chk++; n_err++;
    $display("FAIL drain_timeout: got %0d/%0d pending, want 0", q32.size(), q64.size());
  endtask

  task automatic directed(input string nm, input logic [31:0] ins,
                          input logic [31:0] e32, input logic [2:0] f, input logic i32,
                          input logic [63:0] e64, input logic i64);
    bit ok;
    drain();
    send(ins, ins ^ 32'h5A5A_0000, ok);
    if (!ok) return;
    tick();
    @(negedge clk); #1;
    check({nm, "_v32"}, ov32, 1'b1);
    check({nm, "_imm32"}, imm32, e32);
    check({nm, "_fmt32"}, fmt32, f);
    check({nm, "_ill32"}, ill32, i32);
    check({nm, "_v64"}, ov64, 1'b1);
    check({nm, "_imm64"}, imm64, e64);
    check({nm, "_fmt64"}, fmt64, f);
    check({nm, "_ill64"}, ill64, i64);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_ov32"}, ov32, 1'b0);
    check({nm, "_imm32"}, imm32, 32'h0);
    check({nm, "_fmt32"}, fmt32, 3'b101);
    check({nm, "_ill32"}, ill32, 1'b0);
    check({nm, "_tag32"}, tag32, 32'h0);
    check({nm, "_rdy32"}, rdy32, 1'b0);
    check({nm, "_ov64"}, ov64, 1'b0);
    check({nm, "_imm64"}, imm64, 64'h0);
    check({nm, "_fmt64"}, fmt64, 3'b101);
    check({nm, "_rdy64"}, rdy64, 1'b0);
  endtask

  logic [6:0] ops [14] = '{7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011, 7'b0010011,
                           7'b0011011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                           7'b1101111, 7'b0110011, 7'b0111011, 7'b0010011};

  initial begin
    bit ok;
    int bp_start;
    #1 rst = 1'b1;
    #2 check_reset_outputs("reset");
    tick();
    rst = 1'b0;

    // Directed formats from both XLEN variants
    directed("addi_m1", 32'hFFF00093, 32'hFFFFFFFF, 3'b000, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    directed("sw_m4",   32'hFE112E23, 32'hFFFFFFFC, 3'b111, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    directed("beq_m8",  32'hFE000CE3, 32'hFFFFFFF8, 3'b011, 1'b0, 64'hFFFFFFFFFFFFFFF8, 1'b0);
    directed("jal_2k",  32'h001000EF, 32'h00000800, 3'b010, 1'b0, 64'h0000000000000800, 1'b0);
    directed("lui",     32'h123452B7, 32'h12345000, 3'b001, 1'b0, 64'h0000000012345000, 1'b0);
    directed("lui_neg", 32'h800002B7, 32'h80000000, 3'b001, 1'b0, 64'hFFFFFFFF80000000, 1'b0);
    directed("slli33",  32'h02109093, 32'h00000001, 3'b100, 1'b1, 64'd33, 1'b0);
    directed("bad_op",  32'h0000007F, 32'h00000000, 3'b101, 1'b1, 64'h0, 1'b1);
    directed("addw",    32'h00B5053B, 32'h00000000, 3'b101, 1'b1, 64'h0, 1'b0);

    // Backpressure: A, B fill O and S; C must wait
    drain();
    tick();
    out_ready = 1'b0;
    send(32'h00100093, 32'hA, ok);
    send(32'h00200093, 32'hB, ok);
    tick();
    offer(32'h00300093, 32'hC);
    @(negedge clk); #1;
    check("bp_in_ready_low", rdy32, 1'b0);
    check("bp_head_tag", tag32, 32'hA);
    tick();
    offer(32'h00300093, 32'hC);
    @(negedge clk); #1;
    check("bp_still_low", rdy32, 1'b0);
    check("bp_stable_imm", imm32, 32'h1);
    del_cyc.delete();
    tick();
    out_ready = 1'b1;
    offer(32'h00300093, 32'hC);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk); #1;
      if (rdy32) break;
      tick();
      offer(32'h00300093, 32'hC);
    end
    tick();
    repeat (3) tick();
    check("bp_delivered", del_cyc.size(), 3);
    if (del_cyc.size() == 3) begin
      bp_start = del_cyc[0];
      check("bp_consecutive", del_cyc[2] - bp_start, 2);
    end

    // Flush with O and S full; the input offered in the flush cycle is dropped
    drain();
    tick();
    out_ready = 1'b0;
    send(32'h00400093, 32'h40, ok);
    send(32'h00500093, 32'h50, ok);
    tick();
    flush = 1'b1;
    offer(32'h00600093, 32'h60);
    tick();
    @(negedge clk); #1;
    check("flush_ov32", ov32, 1'b0);
    check("flush_ov64", ov64, 1'b0);
    check("flush_in_ready", rdy32, 1'b1);
    // Flush while idle and ready: offered input must not appear
    tick();
    out_ready = 1'b1;
    flush = 1'b1;
    offer(32'h00700093, 32'h70);
    tick();
    @(negedge clk); #1;
    check("flush_idle_ov32", ov32, 1'b0);

    // Randomized traffic with random backpressure and occasional flushes
    drain();
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [31:0] ins;
      int k;
      r = $urandom_range(0, 15);
      k = $urandom_range(0, 14);
      ins = $urandom;
      if (k < 14) ins[6:0] = ops[k];
      if (r == 0) begin
        tick();
        flush = 1'b1;
        offer(ins, $urandom);
      end else if (r < 4) begin
        tick();
      end else begin
        send(ins, $urandom, ok);
      end
    end
    drain();
    check("final_q32_empty", q32.size(), 0);
    check("final_q64_empty", q64.size(), 0);

    // Asynchronous reset mid-stream
    tick();
    out_ready = 1'b0;
    send(32'h00800093, 32'h80, ok);
    send(32'h00900093, 32'h90, ok);
    @(posedge clk); #3;
    rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk); #1;
    check("rst_hold_rdy", rdy32, 1'b0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk); #1;
    check("post_rst_rdy", rdy32, 1'b1);
    check("post_rst_ov", ov32, 1'b0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
